// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction-fetch port
// and the load/store port. Data accesses win over fetch, but a fetch that has waited
// through STARVE_LIMIT consecutive data grants is forced through. A fetch cancelled by
// a redirect still completes on the memory side, but its response is discarded.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,

  // instruction fetch requester
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_cancel,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  output logic        if_stall,

  // load/store requester
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_byte,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        d_stall,

  // single-port memory
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_byte,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  // Counter value at which a waiting fetch overrides the data port.
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_e;

  state_e           state_q,      state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             drop_q,       drop_d;
  logic             mem_req_q,    mem_req_d;
  logic             mem_we_q,     mem_we_d;
  logic             mem_byte_q,   mem_byte_d;
  logic [AW-1:0]    mem_addr_q,   mem_addr_d;
  logic [DW-1:0]    mem_wdata_q,  mem_wdata_d;

  logic in_idle;
  logic force_if;
  logic grant_d;
  logic grant_if;

  // Arbitration decision, only meaningful in IDLE.
  always_comb begin
    in_idle  = (state_q == IDLE);
    force_if = if_req & d_req & (starve_cnt_q == STARVE_MAX);
    grant_d  = in_idle & d_req & ~force_if;
    grant_if = in_idle & if_req & ~grant_d;
  end

  // Next-state, starvation counter, drop flag and memory-side request registers.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    drop_d       = drop_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_byte_d   = mem_byte_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    unique case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (grant_d) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_byte_d  = d_byte;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          // Count data grants that kept a pending fetch waiting; saturate at the limit.
          if (if_req) begin
            if (starve_cnt_q != STARVE_MAX) begin
              starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
          end else begin
            starve_cnt_d = '0;
          end
        end else if (grant_if) begin
          state_d      = BUSY_IF;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_byte_d   = 1'b0;
          mem_addr_d   = if_addr;
          starve_cnt_d = '0;
        end
      end

      BUSY_IF: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
        end else if (if_cancel) begin
          // Redirect while the fetch is outstanding: the result will be stale.
          drop_d = 1'b1;
        end
      end

      BUSY_D: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        drop_d    = 1'b0;
      end
    endcase
  end

  // State and request registers; synchronous reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      drop_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_byte_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      drop_q       <= drop_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_byte_q   <= mem_byte_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Responses are combinational in the acknowledge cycle so the pipeline sees data without extra latency.
  always_comb begin
    if_valid = mem_ack & (state_q == BUSY_IF) & ~drop_q & ~if_cancel;
    d_valid  = mem_ack & (state_q == BUSY_D);
    if_rdata = mem_rdata;
    d_rdata  = mem_rdata;
    if_stall = if_req & ~if_valid;
    d_stall  = d_req & ~d_valid;
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_byte  = mem_byte_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Memory-side attributes must not move while a request is outstanding.
  a_mem_stable: assert property (@(posedge clk) disable iff (rst)
    (mem_req && !mem_ack) |=> $stable({mem_we, mem_byte, mem_addr, mem_wdata}));

  // The two requesters never complete in the same cycle.
  a_valid_excl: assert property (@(posedge clk) disable iff (rst)
    !(if_valid && d_valid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios followed by randomized traffic, all checked
// against a transaction-level reference model of the arbiter.
module tb_mem_port_arbiter;

  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned CNT_W        = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_cancel, if_valid, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_byte, d_valid, d_stall;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_byte, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_cancel(if_cancel),
    .if_valid (if_valid),
    .if_rdata (if_rdata),
    .if_stall (if_stall),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_byte   (d_byte),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_valid  (d_valid),
    .d_rdata  (d_rdata),
    .d_stall  (d_stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_byte (mem_byte),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the one memory transaction in flight (if any) and its attributes.
  typedef enum logic [1:0] {K_NONE, K_IF, K_D} kind_e;
  kind_e       m_kind   = K_NONE;
  logic [31:0] m_addr   = '0;
  logic [31:0] m_wdata  = '0;
  logic        m_we     = 1'b0;
  logic        m_byte   = 1'b0;
  logic        m_wknown = 1'b1;
  logic        m_stale  = 1'b0;
  int unsigned m_wins   = 0;   // data wins since the waiting fetch last got the port

  // Memory responder and bench control.
  int          lat_cnt   = 0;
  int          fix_lat   = 0;
  logic        spur_en   = 1'b0;
  logic        force_ack = 1'b0;
  logic        rnd_data  = 1'b0;
  logic        chk_en    = 1'b0;
  logic        last_ifv  = 1'b0;
  logic        last_dv   = 1'b0;
  logic        prev_req  = 1'b0;
  logic [31:0] obs_q[$];

  task automatic drive_mem();
    mem_ack = 1'b0;
    if (m_kind != K_NONE) begin
      if (lat_cnt == 0) mem_ack = 1'b1;
      else lat_cnt--;
    end else if (spur_en && ($urandom_range(0, 7) == 0)) begin
      mem_ack = 1'b1;
    end
    if (force_ack) mem_ack = 1'b1;
    if (rnd_data) mem_rdata = $urandom;
  endtask

  task automatic model_step();
    logic ack, e_ifv, e_dv, frc;
    ack   = mem_ack && (m_kind != K_NONE);
    e_ifv = ack && (m_kind == K_IF) && !m_stale && !if_cancel;
    e_dv  = ack && (m_kind == K_D);
    if (chk_en) begin
      check_eq("mem_req",  32'(mem_req),  32'(m_kind != K_NONE));
      check_eq("if_valid", 32'(if_valid), 32'(e_ifv));
      check_eq("d_valid",  32'(d_valid),  32'(e_dv));
      check_eq("if_stall", 32'(if_stall), 32'(if_req && !e_ifv));
      check_eq("d_stall",  32'(d_stall),  32'(d_req && !e_dv));
      check_eq("mem_addr", mem_addr, m_addr);
      check_eq("mem_we",   32'(mem_we),   32'(m_we));
      check_eq("mem_byte", 32'(mem_byte), 32'(m_byte));
      if (m_wknown) check_eq("mem_wdata", mem_wdata, m_wdata);
      if (e_ifv)    check_eq("if_rdata", if_rdata, mem_rdata);
      if (e_dv)     check_eq("d_rdata",  d_rdata,  mem_rdata);
    end
    if (mem_req && !prev_req) obs_q.push_back(mem_addr);
    prev_req = mem_req;
    last_ifv = e_ifv;
    last_dv  = e_dv;

    if (rst) begin
      m_kind = K_NONE; m_addr = '0; m_wdata = '0; m_we = 1'b0; m_byte = 1'b0;
      m_wknown = 1'b1; m_stale = 1'b0; m_wins = 0;
    end else if (m_kind == K_NONE) begin
      frc = if_req && d_req && (m_wins == STARVE_LIMIT);
      if (d_req && !frc) begin
        m_kind = K_D; m_addr = d_addr; m_we = d_we; m_byte = d_byte;
        m_wdata = d_wdata; m_wknown = 1'b1;
        if (!if_req) m_wins = 0;
        else if (m_wins < STARVE_LIMIT) m_wins++;
      end else if (if_req) begin
        m_kind = K_IF; m_addr = if_addr; m_we = 1'b0; m_byte = 1'b0;
        m_wknown = 1'b0; m_wins = 0;
      end
      if (m_kind != K_NONE) lat_cnt = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 2));
    end else if (ack) begin
      m_kind  = K_NONE;
      m_stale = 1'b0;
    end else if ((m_kind == K_IF) && if_cancel) begin
      m_stale = 1'b1;
    end
  endtask

  // tick: apply memory response and evaluate the cycle; caller may check before the edge.
  task automatic tick();
    drive_mem();
    #1;
    model_step();
  endtask

  task automatic cyc();
    tick();
    @(negedge clk);
  endtask

  task automatic quiet();
    if_req = 1'b0; if_cancel = 1'b0; d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0;
    force_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic drive_random();
    rst = ($urandom_range(0, 199) == 0);
    if_cancel = 1'b0;
    if (last_ifv) if_req = 1'b0;
    if (!if_req) begin
      if_req  = 1'($urandom_range(0, 1));
      if_addr = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) if_cancel = 1'b1;
    end else if ($urandom_range(0, 7) == 0) begin
      if_cancel = 1'b1;
      if_addr   = $urandom & 32'hFFFF_FFFC;
    end
    if (last_dv) d_req = 1'b0;
    if (!d_req) begin
      d_req   = 1'($urandom_range(0, 1));
      d_we    = 1'($urandom_range(0, 1));
      d_byte  = 1'($urandom_range(0, 1));
      d_addr  = $urandom;
      d_wdata = $urandom;
    end
  endtask

  logic [31:0] exp_ord [10];

  initial begin
    rst = 1'b1; if_addr = '0; d_addr = '0; d_wdata = '0; mem_ack = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    quiet();
    @(negedge clk);

    // Reset with both requesters asserted, then D wins the first grant.
    if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_addr = 32'h2000; fix_lat = 0;
    cyc();
    chk_en = 1'b1;
    tick();
    check_eq("rst_mem_req",  32'(mem_req),  32'd0);
    check_eq("rst_if_valid", 32'(if_valid), 32'd0);
    check_eq("rst_d_valid",  32'(d_valid),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_eq("rel_idle_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    tick();
    check_eq("rel_req",     32'(mem_req), 32'd1);
    check_eq("rel_grant_d", mem_addr,     32'h2000);
    @(negedge clk);

    // Plain fetch with a two-cycle memory.
    quiet(); do_reset();
    fix_lat = 2; if_req = 1'b1; if_addr = 32'h100;
    cyc();
    tick();
    check_eq("f_mem_req",  32'(mem_req), 32'd1);
    check_eq("f_mem_addr", mem_addr,     32'h100);
    check_eq("f_mem_we",   32'(mem_we),  32'd0);
    @(negedge clk);
    cyc();
    tick();
    check_eq("f_if_valid", 32'(if_valid), 32'd1);
    check_eq("f_if_rdata", if_rdata,      32'hDEAD_BEEF);
    @(negedge clk);
    if_req = 1'b0;
    tick();
    check_eq("f_if_pulse", 32'(if_valid), 32'd0);
    @(negedge clk);

    // Contention: the store goes first, the fetch follows in the next IDLE.
    quiet(); do_reset();
    fix_lat = 0; if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h55;
    cyc();
    tick();
    check_eq("c_we",    32'(mem_we), 32'd1);
    check_eq("c_wdata", mem_wdata,   32'h55);
    check_eq("c_addr",  mem_addr,    32'h2000);
    @(negedge clk);
    d_req = 1'b0;
    cyc();
    tick();
    check_eq("c_if_addr", mem_addr,    32'h100);
    check_eq("c_if_we",   32'(mem_we), 32'd0);
    @(negedge clk);
    quiet(); cyc();

    // Starvation bound: both held, grant order D,D,D,D,IF repeating.
    quiet(); do_reset();
    fix_lat = 0; if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
    obs_q.delete();
    for (int i = 0; i < 20; i++) cyc();
    for (int i = 0; i < 10; i++) exp_ord[i] = ((i % 5) == 4) ? 32'h100 : 32'h2000;
    check_eq("st_grants", 32'(obs_q.size()), 32'd10);
    for (int i = 0; i < 10 && i < obs_q.size(); i++) check_eq("st_order", obs_q[i], exp_ord[i]);

    // Cancel one cycle after the grant: result dropped, redirected fetch completes.
    quiet(); do_reset();
    fix_lat = 2; if_req = 1'b1; if_addr = 32'h100;
    cyc();
    if_cancel = 1'b1; if_addr = 32'h200;
    cyc();
    if_cancel = 1'b0;
    cyc();
    tick();
    check_eq("x_ack",  32'(mem_ack),  32'd1);
    check_eq("x_drop", 32'(if_valid), 32'd0);
    @(negedge clk);
    cyc();
    tick();
    check_eq("x_readdr", mem_addr, 32'h200);
    @(negedge clk);
    cyc();
    tick();
    check_eq("x_valid", 32'(if_valid), 32'd1);
    @(negedge clk);
    quiet(); cyc();

    // Cancel in the acknowledge cycle suppresses the valid.
    quiet(); do_reset();
    fix_lat = 0; if_req = 1'b1; if_addr = 32'h300;
    cyc();
    if_cancel = 1'b1; if_addr = 32'h400;
    tick();
    check_eq("y_cancel_ack", 32'(if_valid), 32'd0);
    @(negedge clk);
    if_cancel = 1'b0;
    cyc();
    tick();
    check_eq("y_valid", 32'(if_valid), 32'd1);
    @(negedge clk);
    quiet(); cyc();

    // Reset during a load, then a late acknowledge.
    quiet(); do_reset();
    fix_lat = 3; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; d_req = 1'b0; force_ack = 1'b1;
    tick();
    check_eq("r_d_valid", 32'(d_valid), 32'd0);
    check_eq("r_mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    force_ack = 1'b0;
    cyc();

    // Randomized traffic with variable latency, spurious acks and occasional resets.
    quiet(); do_reset();
    fix_lat = -1; spur_en = 1'b1; rnd_data = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
